// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
//   Four-master round-robin arbiter for a shared bus. A master keeps the bus
//   for as long as it holds its request; it is never preempted. When the owner
//   drops its request, the bus passes on the same edge to the next requester
//   after the owner in rotation, so there is no idle cycle between owners. The
//   owner's address, strobe, read/write and write-data are muxed onto the
//   shared bus. A sticky flag records any single tenure that reaches TIMEOUT
//   cycles; raising it does not change arbitration.
//
// Ports
//   clk          system clock, rising edge
//   reset        synchronous, active-high
//   m_req_       [3:0]   per-master request, active-low
//   m_grnt_      [3:0]   per-master grant, active-low, registered
//   m_addr       [119:0] master word addresses, master i at [30i+29:30i]
//   m_as_        [3:0]   per-master address strobe, active-low
//   m_rw         [3:0]   per-master read/write (READ = 1, WRITE = 0)
//   m_wr_data    [127:0] master write data, master i at [32i+31:32i]
//   s_addr       [29:0]  shared-bus address of the owner (0 when idle)
//   s_as_                shared-bus address strobe (1 when idle)
//   s_rw                 shared-bus read/write (READ when idle)
//   s_wr_data    [31:0]  shared-bus write data (0 when idle)
//   owner        [1:0]   current owner index, meaningful only while busy
//   busy                 a master holds the grant
//   timeout_err          sticky: some owner held the bus TIMEOUT cycles
// -----------------------------------------------------------------------------
module bus_arbiter #(
  parameter int unsigned TIMEOUT = 255  // legal range 1..255
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [3:0]   m_req_,
  output logic [3:0]   m_grnt_,
  input  logic [119:0] m_addr,
  input  logic [3:0]   m_as_,
  input  logic [3:0]   m_rw,
  input  logic [127:0] m_wr_data,
  output logic [29:0]  s_addr,
  output logic         s_as_,
  output logic         s_rw,
  output logic [31:0]  s_wr_data,
  output logic [1:0]   owner,
  output logic         busy,
  output logic         timeout_err
);

  localparam logic READ  = 1'b1;
  localparam logic WRITE = 1'b0;

  // The flag sets on the edge where the count of retained cycles reaches
  // TIMEOUT, i.e. while the registered count still reads TIMEOUT-1.
  localparam logic [7:0] HOLD_LIMIT = 8'(TIMEOUT - 1);
  localparam logic [7:0] HOLD_MAX   = 8'hFF;

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  owner_q, owner_d;
  logic [1:0]  last_q,  last_d;
  logic [7:0]  hold_q,  hold_d;
  logic        err_q,   err_d;
  logic [3:0]  grnt_q,  grnt_d;

  logic [3:0]  req;          // active-high view of the requests
  logic [1:0]  search_base;  // rotation starts one past this index
  logic [1:0]  search_idx;
  logic [1:0]  pick;
  logic        found;

  assign req = ~m_req_;

  // Round-robin search: base+1, base+2, base+3, base (mod 4). When owned the
  // base is the owner, which always equals last, so one pointer serves both.
  always_comb begin
    // NOTE: every variable written here gets a default first so no path can
    // leave it unassigned; otherwise synthesis would infer a latch.
    search_base = (state_q == OWNED) ? owner_q : last_q;
    search_idx  = '0;
    pick        = '0;
    found       = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      search_idx = search_base + 2'(i);
      if (!found && req[search_idx]) begin
        found = 1'b1;
        pick  = search_idx;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    hold_d  = hold_q;
    err_d   = err_q;

    unique case (state_q)
      IDLE: begin
        hold_d = '0;
        if (found) begin
          state_d = OWNED;
          owner_d = pick;
          last_d  = pick;
        end
      end
      OWNED: begin
        if (req[owner_q]) begin
          // Owner retained: count the tenure, saturating.
          if (hold_q == HOLD_LIMIT) err_d = 1'b1;
          if (hold_q != HOLD_MAX)   hold_d = hold_q + 8'd1;
        end else if (found) begin
          // Handover on the release edge; the owner's own request is
          // already deasserted, so the search cannot return it.
          owner_d = pick;
          last_d  = pick;
          hold_d  = '0;
        end else begin
          state_d = IDLE;
          hold_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    grnt_d = (state_d == OWNED) ? ~(4'b0001 << owner_d) : 4'b1111;
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // values from before the edge, independent of statement order.
    if (reset) begin
      state_q <= IDLE;
      owner_q <= 2'd0;
      last_q  <= 2'd3;      // master 0 gets first priority after reset
      hold_q  <= '0;
      err_q   <= 1'b0;
      grnt_q  <= 4'b1111;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
      err_q   <= err_d;
      grnt_q  <= grnt_d;
    end
  end

  // Shared-bus mux, driven only from the owner register so a non-owner's
  // strobe can never reach the bus.
  always_comb begin
    s_addr    = '0;
    s_as_     = 1'b1;
    s_rw      = READ;
    s_wr_data = '0;
    if (state_q == OWNED) begin
      s_addr    = m_addr[30*owner_q +: 30];
      s_as_     = m_as_[owner_q];
      s_rw      = m_rw[owner_q];
      s_wr_data = m_wr_data[32*owner_q +: 32];
    end
  end

  assign m_grnt_     = grnt_q;
  assign owner       = owner_q;
  assign busy        = (state_q == OWNED);
  assign timeout_err = err_q;

  // WRITE is named for readers of the encoding; it drives nothing here.
  logic unused_write;
  assign unused_write = WRITE;

endmodule

// File: tb/tb_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bus_arbiter
//   Directed scenarios for bus_arbiter (TIMEOUT = 4). Each stimulus step drives
//   the request vector at a falling edge and, at the following rising edge,
//   pushes the hand-computed expected grant and error flag into a queue. A
//   separate monitor samples 2 time units after every rising edge, pops one
//   expectation if present and compares grant, busy, owner, error flag and
//   the shared-bus fields (derived from the bench's own master vectors).
// -----------------------------------------------------------------------------
module tb_bus_arbiter;

  localparam int unsigned TIMEOUT = 4;
  localparam logic        READ    = 1'b1;

  logic         clk;
  logic         reset;
  logic [3:0]   m_req_;
  logic [3:0]   m_grnt_;
  logic [119:0] m_addr;
  logic [3:0]   m_as_;
  logic [3:0]   m_rw;
  logic [127:0] m_wr_data;
  logic [29:0]  s_addr;
  logic         s_as_;
  logic         s_rw;
  logic [31:0]  s_wr_data;
  logic [1:0]   owner;
  logic         busy;
  logic         timeout_err;

  bus_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .reset       (reset),
    .m_req_      (m_req_),
    .m_grnt_     (m_grnt_),
    .m_addr      (m_addr),
    .m_as_       (m_as_),
    .m_rw        (m_rw),
    .m_wr_data   (m_wr_data),
    .s_addr      (s_addr),
    .s_as_       (s_as_),
    .s_rw        (s_rw),
    .s_wr_data   (s_wr_data),
    .owner       (owner),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] grnt;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] low_index(input logic [3:0] g);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) if (!g[i]) idx = 2'(i);
    return idx;
  endfunction

  // Monitor: one-hot-low grant every cycle, scoreboard compare when queued.
  initial begin
    exp_t       e;
    logic       e_busy;
    logic [1:0] e_own;
    forever begin
      @(posedge clk);
      #2;
      check("grant_at_most_one_low", 128'($countones(~m_grnt_) <= 1), 128'(1));
      if (exp_q.size() > 0) begin
        e      = exp_q.pop_front();
        e_busy = (e.grnt != 4'b1111);
        e_own  = low_index(e.grnt);
        check("m_grnt_",     128'(m_grnt_),     128'(e.grnt));
        check("busy",        128'(busy),        128'(e_busy));
        check("timeout_err", 128'(timeout_err), 128'(e.err));
        if (e_busy) begin
          check("owner",     128'(owner),     128'(e_own));
          check("s_addr",    128'(s_addr),    128'(m_addr[30*e_own +: 30]));
          check("s_as_",     128'(s_as_),     128'(m_as_[e_own]));
          check("s_rw",      128'(s_rw),      128'(m_rw[e_own]));
          check("s_wr_data", 128'(s_wr_data), 128'(m_wr_data[32*e_own +: 32]));
        end else begin
          check("s_addr_idle",    128'(s_addr),    128'(0));
          check("s_as_idle",      128'(s_as_),     128'(1));
          check("s_rw_idle",      128'(s_rw),      128'(READ));
          check("s_wr_data_idle", 128'(s_wr_data), 128'(0));
        end
      end
    end
  end

  // One cycle of stimulus plus the expected state after its rising edge.
  task automatic step(input logic rst, input logic [3:0] req,
                      input logic [3:0] e_grnt, input logic e_err);
    exp_t e;
    @(negedge clk);
    reset  = rst;
    m_req_ = req;
    @(posedge clk);
    e.grnt = e_grnt;
    e.err  = e_err;
    exp_q.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset  = 1'b1;
    m_req_ = 4'b1111;
    m_as_  = 4'b1010;   // masters 0 and 2 strobing, whoever owns
    m_rw   = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      m_addr[30*i +: 30]    = 30'h0123_4560 + 30'(i * 30'h0101_0101);
      m_wr_data[32*i +: 32] = 32'hDEAD_0000 | 32'(i * 32'h0000_1111);
    end

    // Reset state, then first grant goes to master 0 (last = 3).
    step(1'b1, 4'b0000, 4'b1111, 1'b0);   // requests ignored during reset
    step(1'b0, 4'b0000, 4'b1110, 1'b0);   // 1-cycle latency, owner 0
    step(1'b0, 4'b0000, 4'b1110, 1'b0);   // retained, no preemption

    // Full rotation 0,1,2,3,0; each owner holds two edges, released master
    // re-requests the next cycle and queues behind the others.
    step(1'b1, 4'b1111, 4'b1111, 1'b0);
    step(1'b0, 4'b0000, 4'b1110, 1'b0);
    step(1'b0, 4'b0000, 4'b1110, 1'b0);
    step(1'b0, 4'b0001, 4'b1101, 1'b0);   // 0 releases -> 1
    step(1'b0, 4'b0000, 4'b1101, 1'b0);   // 0 back, waits
    step(1'b0, 4'b0010, 4'b1011, 1'b0);   // 1 releases -> 2, not 0
    step(1'b0, 4'b0000, 4'b1011, 1'b0);
    step(1'b0, 4'b0100, 4'b0111, 1'b0);   // 2 releases -> 3
    step(1'b0, 4'b0000, 4'b0111, 1'b0);
    step(1'b0, 4'b1000, 4'b1110, 1'b0);   // 3 releases -> wraps to 0

    // Master 2 owns, master 1 waits, handover on release, then idle.
    m_as_ = 4'b1001;                      // non-owners 1,2 low in places
    step(1'b1, 4'b1111, 4'b1111, 1'b0);
    step(1'b0, 4'b1111, 4'b1111, 1'b0);   // no request: stay idle
    step(1'b0, 4'b1011, 4'b1011, 1'b0);   // only 2 requests
    step(1'b0, 4'b1001, 4'b1011, 1'b0);   // 1 requests: no preemption
    step(1'b0, 4'b1101, 4'b1101, 1'b0);   // 2 releases -> 1 same edge
    step(1'b0, 4'b1111, 4'b1111, 1'b0);   // 1 releases, nobody -> idle
    step(1'b0, 4'b1111, 4'b1111, 1'b0);

    // Timeout: master 3 holds; flag sets on the 4th retained edge.
    m_as_ = 4'b0110;
    step(1'b1, 4'b1111, 4'b1111, 1'b0);
    step(1'b0, 4'b0111, 4'b0111, 1'b0);   // grant edge, count 0
    step(1'b0, 4'b0111, 4'b0111, 1'b0);   // 1st owned edge
    step(1'b0, 4'b0111, 4'b0111, 1'b0);
    step(1'b0, 4'b0111, 4'b0111, 1'b0);   // 3rd: still clear
    step(1'b0, 4'b0111, 4'b0111, 1'b1);   // 4th: sets
    step(1'b0, 4'b0111, 4'b0111, 1'b1);
    step(1'b0, 4'b1111, 4'b1111, 1'b1);   // sticky after release
    step(1'b0, 4'b1111, 4'b1111, 1'b1);
    step(1'b1, 4'b1111, 4'b1111, 1'b0);   // only reset clears it

    // Reset while master 1 owns with 1 and 2 requesting.
    step(1'b0, 4'b1101, 4'b1101, 1'b0);
    step(1'b0, 4'b1001, 4'b1101, 1'b0);
    step(1'b1, 4'b1001, 4'b1111, 1'b0);   // grant revoked at reset edge
    step(1'b1, 4'b1001, 4'b1111, 1'b0);   // not granted during reset
    step(1'b0, 4'b1001, 4'b1101, 1'b0);   // search from 0: master 1

    // Let the monitor drain, bounded.
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    #3;
    check("queue_drained", 128'(exp_q.size()), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255: hold-cycle count at which timeout_err sets; legal range 1..255.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 m_req_  input  4  per-master bus request, active-low; bit i belongs to master i.
REQ-005 m_grnt_  output  4  per-master grant, active-low, registered; at most one bit low at any time.
REQ-006 m_addr  input  120  master word addresses, 4x30, packed; master i at [30i+29:30i].
REQ-007 m_as_  input  4  per-master address strobe, active-low.
REQ-008 m_rw  input  4  per-master read/write, codebase READ/WRITE encoding.
REQ-009 m_wr_data  input  128  master write data, 4x32, packed; master i at [32i+31:32i].
REQ-010 s_addr  output  30  shared-bus word address of the current owner.
REQ-011 s_as_  output  1  shared-bus address strobe, active-low.
REQ-012 s_rw  output  1  shared-bus read/write.
REQ-013 s_wr_data  output  32  shared-bus write data.
REQ-014 owner  output  2  index of the current owner; valid only while busy=1.
REQ-015 busy  output  1  1 while any master holds the grant.
REQ-016 timeout_err  output  1  sticky flag: an owner held the bus for TIMEOUT consecutive cycles.

Function
REQ-017 Two states: IDLE (no owner, m_grnt_=4'b1111) and OWNED (one owner, m_grnt_[owner]=0).
REQ-018 Round-robin pointer last: index of the most recent owner; search order is last+1, last+2, last+3, last, all modulo 4.
REQ-019 IDLE: at an edge where any m_req_ bit is 0, select the first requester in search order, go to OWNED, and drive its grant low from that edge on (1-cycle request-to-grant latency).
REQ-020 IDLE with m_req_=4'b1111: stay in IDLE.
REQ-021 OWNED with m_req_[owner]=0: keep the owner; never preempt, whatever other requests are pending.
REQ-022 OWNED, owner releases (m_req_[owner]=1) while another master requests: hand over at the same edge to the first requester in search order starting at owner+1; no idle bubble; new grant low and old grant high at the same edge.
REQ-023 OWNED, owner releases with no other requester: go to IDLE at that edge.
REQ-024 last updates to the new owner at every grant edge.
REQ-025 A master that releases and re-requests in the next cycle waits behind all other pending requesters.
REQ-026 Shared-bus mux, combinational from the owner register: in OWNED, s_addr/s_as_/s_rw/s_wr_data = the owner's slice; in IDLE, s_addr=0, s_as_=1, s_rw=READ, s_wr_data=0.
REQ-027 Non-owner m_as_ is ignored; it never reaches s_as_.
REQ-028 busy = (state==OWNED); owner = owner register.
REQ-029 8-bit hold counter: clears on every grant edge (including handover) and in IDLE; increments each OWNED cycle; saturates at 255.
REQ-030 When hold count == TIMEOUT-1 and the same owner is retained, timeout_err sets at that edge; it stays 1 until reset; arbitration is unaffected.

Reset
REQ-031 With reset=1 at an edge: state=IDLE, m_grnt_=4'b1111, last=3 (master 0 has first priority), owner=0, hold count=0, timeout_err=0; s_* take their IDLE values in the same cycle.
REQ-032 Reset mid-ownership revokes the grant at that edge; requests present during reset are not granted until the first edge after reset=0.
REQ-033 reset has priority over all other transitions.

Verification
REQ-034 After reset, m_req_=4'b0000 -> m_grnt_=4'b1110 one edge later; owner=0, busy=1; s_addr equals m_addr[29:0].
REQ-035 All four masters hold requests, each owner releases after 2 cycles -> grant order 0,1,2,3,0; handover without a gap; m_grnt_ never shows two low bits.
REQ-036 Master 2 owns, master 1 requests, master 2 releases -> m_grnt_=4'b1101 at the release edge; then master 1 releases with no other request -> m_grnt_=4'b1111, busy=0, s_as_=1, s_addr=0.
REQ-037 TIMEOUT=4, master 3 holds for 6 cycles -> timeout_err=1 at the 4th owned edge, stays 1 after release, clears only on reset.
REQ-038 Reset asserted while master 1 owns and masters 1 and 2 request -> m_grnt_=4'b1111 at that edge; first edge after reset=0 grants master 1 (last=3 search order).
